// File: rtl/matmul_pkg.sv
// Shared types, sizing defaults and cycle-count helpers for the matmul block.
// Both the RTL and its benches import this package.
package matmul_pkg;

    localparam int MATMUL_MAX_ELS = 256;

    typedef struct packed {
        int rows;
        int cols;
    } matmul_dims_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        CALCULATE = 3'd2,
        WRITE     = 3'd3,
        ERROR     = 3'd4
    } matmul_state_t;

    // Cycles spent in READ: both streams share the counter, so the longer one sets the length.
    function automatic int matmul_read_time(input matmul_dims_t dims_a, input matmul_dims_t dims_b);
        int a_els;
        int b_els;
        a_els = dims_a.rows * dims_a.cols;
        b_els = dims_b.rows * dims_b.cols;
        return (a_els > b_els) ? a_els : b_els;
    endfunction

    function automatic int matmul_compute_time(input matmul_dims_t dims_a, input matmul_dims_t dims_b);
        return dims_a.rows * dims_a.cols * dims_b.cols;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed 32-bit multiply-accumulate; clr restarts the running sum from zero
// for the product presented in the same cycle.
module matmul_mac (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               clr,
    input  logic signed [31:0] op_a,
    input  logic signed [31:0] op_b,
    output logic signed [31:0] sum
);

    logic signed [31:0] acc_q;
    logic signed [31:0] acc_d;
    logic signed [31:0] base_s;

    // Sum is exposed combinationally so the final product of a dot product lands in the same edge.
    always_comb begin
        base_s = clr ? 32'sd0 : acc_q;
        sum    = base_s + op_a * op_b;
        if (en) begin
            acc_d = sum;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= 32'sd0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul.sv
// Sequential integer matrix multiplier C = A x B: stream A/B in, one MAC per
// cycle, stream C out, with the host tracking progress through `state`.
module matmul
    import matmul_pkg::*;
#(
    parameter int MAX_ELS = MATMUL_MAX_ELS
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output matmul_state_t state,
    input  matmul_dims_t  dims_a,
    input  logic [31:0]   in_a,
    input  matmul_dims_t  dims_b,
    input  logic [31:0]   in_b,
    output logic [31:0]   out_c
);

    localparam int AW = (MAX_ELS > 1) ? $clog2(MAX_ELS) : 1;

    matmul_state_t state_q, state_d;
    matmul_dims_t  dims_a_q, dims_a_d, dims_b_q, dims_b_d;
    int            cnt_q, cnt_d, k_q, k_d, col_q, col_d, row_q, row_d;
    logic [31:0]   out_c_q, out_c_d;

    logic [31:0]   a_mem [MAX_ELS];
    logic [31:0]   b_mem [MAX_ELS];
    logic [31:0]   c_mem [MAX_ELS];

    longint        a_req_s, b_req_s, c_req_s;
    logic          dims_bad_s;
    int            a_els_s, b_els_s, c_els_s, read_len_s, comp_len_s;
    int            a_idx_s, b_idx_s, c_idx_s;
    logic          a_we_s, b_we_s, c_we_s, mac_en_s, mac_clr_s;
    logic [31:0]   mac_sum_s;

    // 64-bit products keep oversize requests such as 1000x1000 from wrapping into range.
    always_comb begin
        a_req_s    = longint'(dims_a.rows) * longint'(dims_a.cols);
        b_req_s    = longint'(dims_b.rows) * longint'(dims_b.cols);
        c_req_s    = longint'(dims_a.rows) * longint'(dims_b.cols);
        dims_bad_s = (dims_a.rows < 32'sd1) || (dims_a.cols < 32'sd1) ||
                     (dims_b.rows < 32'sd1) || (dims_b.cols < 32'sd1) ||
                     (a_req_s > longint'(MAX_ELS)) || (b_req_s > longint'(MAX_ELS)) ||
                     (c_req_s > longint'(MAX_ELS)) || (dims_a.cols != dims_b.rows);
    end

    // Sizes and buffer addresses derived from the latched dimensions.
    always_comb begin
        a_els_s    = dims_a_q.rows * dims_a_q.cols;
        b_els_s    = dims_b_q.rows * dims_b_q.cols;
        c_els_s    = dims_a_q.rows * dims_b_q.cols;
        read_len_s = matmul_read_time(dims_a_q, dims_b_q);
        comp_len_s = matmul_compute_time(dims_a_q, dims_b_q);
        a_idx_s    = row_q * dims_a_q.cols + k_q;
        b_idx_s    = k_q * dims_b_q.cols + col_q;
        c_idx_s    = row_q * dims_b_q.cols + col_q;
    end

    assign mac_clr_s = (k_q == 32'sd0);

    matmul_mac u_mac (
        .clk  (clk),
        .rstn (rstn),
        .en   (mac_en_s),
        .clr  (mac_clr_s),
        .op_a (a_mem[a_idx_s[AW-1:0]]),
        .op_b (b_mem[b_idx_s[AW-1:0]]),
        .sum  (mac_sum_s)
    );

    // Next-state, counter and buffer-write control.
    always_comb begin
        state_d  = state_q;
        dims_a_d = dims_a_q;
        dims_b_d = dims_b_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        col_d    = col_q;
        row_d    = row_q;
        out_c_d  = out_c_q;
        a_we_s   = 1'b0;
        b_we_s   = 1'b0;
        c_we_s   = 1'b0;
        mac_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dims_a_d = dims_a;
                    dims_b_d = dims_b;
                    cnt_d    = 32'sd0;
                    state_d  = dims_bad_s ? ERROR : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (start) begin
                    state_d = ERROR;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                a_we_s = (cnt_q < a_els_s);
                b_we_s = (cnt_q < b_els_s);
                if (cnt_q == read_len_s - 32'sd1) begin
                    state_d = CALCULATE;
                    cnt_d   = 32'sd0;
                    k_d     = 32'sd0;
                    col_d   = 32'sd0;
                    row_d   = 32'sd0;
                end else begin
                    cnt_d = cnt_q + 32'sd1;
                end
            end
            CALCULATE: begin
                mac_en_s = 1'b1;
                // Last k of a dot product: commit the element and step to the next (row, col).
                if (k_q == dims_a_q.cols - 32'sd1) begin
                    c_we_s = 1'b1;
                    k_d    = 32'sd0;
                    if (col_q == dims_b_q.cols - 32'sd1) begin
                        col_d = 32'sd0;
                        row_d = row_q + 32'sd1;
                    end else begin
                        col_d = col_q + 32'sd1;
                    end
                end else begin
                    k_d = k_q + 32'sd1;
                end
                if (cnt_q == comp_len_s - 32'sd1) begin
                    state_d = WRITE;
                    cnt_d   = 32'sd0;
                end else begin
                    cnt_d = cnt_q + 32'sd1;
                end
            end
            WRITE: begin
                if (cnt_q < c_els_s) begin
                    out_c_d = c_mem[cnt_q[AW-1:0]];
                end else begin
                    out_c_d = out_c_q;
                end
                if (cnt_q == c_els_s) begin
                    state_d = IDLE;
                    cnt_d   = 32'sd0;
                end else begin
                    cnt_d = cnt_q + 32'sd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            dims_a_q <= '{rows: 32'sd0, cols: 32'sd0};
            dims_b_q <= '{rows: 32'sd0, cols: 32'sd0};
            cnt_q    <= 32'sd0;
            k_q      <= 32'sd0;
            col_q    <= 32'sd0;
            row_q    <= 32'sd0;
            out_c_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            dims_a_q <= dims_a_d;
            dims_b_q <= dims_b_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            col_q    <= col_d;
            row_q    <= row_d;
            out_c_q  <= out_c_d;
        end
    end

    // Element buffers; contents are only meaningful after being written, so no reset.
    always_ff @(posedge clk) begin
        if (a_we_s) begin
            a_mem[cnt_q[AW-1:0]] <= in_a;
        end
        if (b_we_s) begin
            b_mem[cnt_q[AW-1:0]] <= in_b;
        end
        if (c_we_s) begin
            c_mem[c_idx_s[AW-1:0]] <= mac_sum_s;
        end
    end

    assign state = state_q;
    assign out_c = out_c_q;

endmodule

// File: tb/tb_matmul.sv
// Directed self-checking bench for matmul: error paths, several products with
// hand-computed results, start-hold in ERROR, and mid-operation reset.
module tb_matmul;
    import matmul_pkg::*;

    logic          clk;
    logic          rstn;
    logic          start;
    matmul_state_t state;
    matmul_dims_t  dims_a;
    logic [31:0]   in_a;
    matmul_dims_t  dims_b;
    logic [31:0]   in_b;
    logic [31:0]   out_c;

    int checks;
    int errors;
    int mat_a [16];
    int mat_b [16];
    int exp_c [16];

    matmul #(.MAX_ELS(256)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .state  (state),
        .dims_a (dims_a),
        .in_a   (in_a),
        .dims_b (dims_b),
        .in_b   (in_b),
        .out_c  (out_c)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic matmul_dims_t mk(input int r, input int c);
        matmul_dims_t d;
        d.rows = r;
        d.cols = c;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic try_err(input string tag, input matmul_dims_t da, input matmul_dims_t db);
        dims_a = da;
        dims_b = db;
        start  = 1'b1;
        step();
        check_val({tag, "_err"}, 32'(state), 32'(ERROR));
        start = 1'b0;
        step();
        check_val({tag, "_idle"}, 32'(state), 32'(IDLE));
    endtask

    task automatic run_mm(input string tag, input matmul_dims_t da, input matmul_dims_t db,
                          input int r_exp, input int k_exp, input int n_c);
        int a_n;
        int b_n;
        a_n = da.rows * da.cols;
        b_n = db.rows * db.cols;
        check_val({tag, "_rtime"}, 32'(matmul_read_time(da, db)), 32'(r_exp));
        check_val({tag, "_ktime"}, 32'(matmul_compute_time(da, db)), 32'(k_exp));
        dims_a = da;
        dims_b = db;
        in_a   = 32'd7777;
        in_b   = 32'd8888;
        start  = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_read"}, 32'(state), 32'(READ));
        dims_a = mk(0, 0);
        dims_b = mk(0, 0);
        for (int i = 0; i < r_exp; i++) begin
            in_a = (i < a_n) ? 32'(mat_a[i]) : 32'hDEAD_BEEF;
            in_b = (i < b_n) ? 32'(mat_b[i]) : 32'hDEAD_BEEF;
            step();
        end
        check_val({tag, "_calc"}, 32'(state), 32'(CALCULATE));
        for (int i = 0; i < k_exp - 1; i++) begin
            step();
        end
        check_val({tag, "_calc_end"}, 32'(state), 32'(CALCULATE));
        step();
        check_val({tag, "_write"}, 32'(state), 32'(WRITE));
        for (int j = 0; j < n_c; j++) begin
            step();
            check_val($sformatf("%s_c%0d", tag, j), out_c, 32'(exp_c[j]));
        end
        step();
        check_val({tag, "_done"}, 32'(state), 32'(IDLE));
        check_val({tag, "_hold"}, out_c, 32'(exp_c[n_c-1]));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rstn   = 1'b0;
        start  = 1'b0;
        dims_a = mk(0, 0);
        dims_b = mk(0, 0);
        in_a   = 32'd0;
        in_b   = 32'd0;
        step();
        step();
        check_val("rst_state", 32'(state), 32'(IDLE));
        check_val("rst_out", out_c, 32'd0);
        rstn = 1'b1;
        step();

        try_err("too_large", mk(1000, 1000), mk(1000, 1000));
        try_err("mismatch", mk(2, 3), mk(4, 2));
        try_err("zero_dim", mk(0, 2), mk(2, 2));
        try_err("a_over", mk(16, 17), mk(17, 1));
        try_err("c_over", mk(17, 1), mk(1, 17));

        // start held high keeps the block parked in ERROR
        dims_a = mk(2, 3);
        dims_b = mk(4, 2);
        start  = 1'b1;
        step();
        check_val("hold_err0", 32'(state), 32'(ERROR));
        step();
        check_val("hold_err1", 32'(state), 32'(ERROR));
        step();
        check_val("hold_err2", 32'(state), 32'(ERROR));
        start = 1'b0;
        step();
        check_val("hold_idle", 32'(state), 32'(IDLE));

        // exactly MAX_ELS elements is accepted; abort with reset once in READ
        dims_a = mk(16, 16);
        dims_b = mk(16, 16);
        start  = 1'b1;
        step();
        start = 1'b0;
        check_val("max_read", 32'(state), 32'(READ));
        rstn = 1'b0;
        #1;
        check_val("max_abort", 32'(state), 32'(IDLE));
        #2;
        rstn = 1'b1;
        step();

        mat_a = '{0: 10, 1: 20, 2: 30, 3: 40, default: 0};
        mat_b = '{0: 10, 1: 20, 2: 30, 3: 40, default: 0};
        exp_c = '{0: 700, 1: 1000, 2: 1500, 3: 2200, default: 0};
        run_mm("sq2", mk(2, 2), mk(2, 2), 4, 8, 4);

        // reset during CALCULATE clears state and out_c without a clock edge
        dims_a = mk(2, 2);
        dims_b = mk(2, 2);
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a = 32'(mat_a[i]);
            in_b = 32'(mat_b[i]);
            step();
        end
        step();
        step();
        check_val("abort_calc", 32'(state), 32'(CALCULATE));
        check_val("abort_prev_out", out_c, 32'd2200);
        rstn = 1'b0;
        #1;
        check_val("abort_state", 32'(state), 32'(IDLE));
        check_val("abort_out", out_c, 32'd0);
        #2;
        rstn = 1'b1;
        step();

        mat_a = '{0: 1, 1: 2, 2: 3, 3: 4, 4: 5, 5: 6, default: 0};
        mat_b = '{0: 1, 1: 1, 2: 1, default: 0};
        exp_c = '{0: 6, 1: 15, default: 0};
        run_mm("nsq", mk(2, 3), mk(3, 1), 6, 6, 2);

        mat_a = '{0: -3, 1: 5, default: 0};
        mat_b = '{0: 7, 1: -2, default: 0};
        exp_c = '{0: -31, default: 0};
        run_mm("neg", mk(1, 2), mk(2, 1), 2, 2, 1);

        mat_a = '{0: 65536, default: 0};
        mat_b = '{0: 65536, default: 0};
        exp_c = '{0: 0, default: 0};
        run_mm("wrap", mk(1, 1), mk(1, 1), 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul.md
# matmul

Sequential integer matrix multiplier computing C = A × B for small matrices. A host presents the dimensions of A and B and pulses `start`. The block streams both matrices in row-major order, one element per cycle. It then computes with one multiply-accumulate per cycle and streams C out in row-major order. The host follows the exported `state` output, so it is a standalone compute block with a purely cycle-counted handshake.

## Interface
- `MAX_ELS`, default 256: maximum element count of A, of B and of C; internal buffers of this many 32-bit words each.
- `clk` input 1: single clock; all state changes on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: request a multiplication; sampled only in IDLE (and ERROR, see below).
- `state` output `matmul_state_t`: current FSM state, registered.
- `dims_a` input `matmul_dims_t`: {rows, cols} of A; packed struct, `rows` is the upper 32-bit int and `cols` the lower 32-bit int.
- `in_a` input 32 (int): A element stream.
- `dims_b` input `matmul_dims_t`: {rows, cols} of B.
- `in_b` input 32 (int): B element stream.
- `out_c` output 32 (int): C element stream, registered.

## Operation
- States and encoding: IDLE=0, READ=1, CALCULATE=2, WRITE=3, ERROR=4.
- IDLE, `start`=1: latch `dims_a` and `dims_b`, then validate.
  - Go to ERROR if any dimension < 1.
  - Go to ERROR if a.rows·a.cols > MAX_ELS, b.rows·b.cols > MAX_ELS, or a.rows·b.cols > MAX_ELS.
  - Go to ERROR if a.cols ≠ b.rows.
  - Otherwise go to READ with the element counter at 0.
  - Products are computed in 64 bits, so 1000×1000 correctly flags "too large".
- ERROR: go to IDLE on the first edge with `start`=0; stay in ERROR while `start`=1.
- READ, edge i (i = 0 … R−1, where R = `matmul_read_time` = max(a_els, b_els)):
  - If i < a_els, A[i] ← `in_a`.
  - If i < b_els, B[i] ← `in_b`.
  - After the R-th READ edge, go to CALCULATE.
- CALCULATE: performs exactly K = `matmul_compute_time` = a.rows·a.cols·b.cols MAC steps, one per edge.
  - For each C element (row-major), the accumulator starts at 0 and computes sum over k of A[r·a.cols+k]·B[k·b.cols+c].
  - After the K-th edge, go to WRITE with the output index at 0.
- WRITE, edge j:
  - If j < c_els, `out_c` ← C[j].
  - On edge c_els+1, go to IDLE; `out_c` holds C[c_els−1].
- Arithmetic: signed 32-bit; products and sums wrap modulo 2^32.
- `start` is ignored in READ, CALCULATE and WRITE. Dimension inputs are ignored after latching.

## Timing
- Reset (asynchronous, `rstn`=0): `state`=IDLE, `out_c`=0, all counters and the accumulator 0. Buffers need no reset.
- Reset asserted mid-operation aborts immediately to IDLE; the next operation is a full restart.
- Start to READ: 1 edge.
- Total latency from the start edge to IDLE: 1 + R + K + c_els + 1 edges.
- Host drives element i before READ edge i (on the falling edge is sufficient); values presented on the start edge are not captured.
- After WRITE edge j+1, `out_c` is valid for C[j] until the next edge.

## Structure
- Package `matmul_pkg` holds the shared definitions:
  - `matmul_dims_t` (packed struct {int rows; int cols}).
  - `matmul_state_t` enum.
  - `MAX_ELS` default.
  - Functions `matmul_read_time(dims_a, dims_b)` and `matmul_compute_time(dims_a, dims_b)`, used by both RTL and benches.
- One natural sub-module: `matmul_mac`, a 32-bit signed multiply-accumulate with a clear input. The FSM, buffers and index counters live in `matmul`.

## Test plan
- Too large: `start`=1, both dims {1000,1000} → `state`=ERROR after 1 edge; `start`=0 → IDLE after the next edge.
- Mismatch: dims_a {2,3}, dims_b {4,2}, `start`=1 → ERROR; `start`=0 → IDLE.
- 2×2 square: A = B = [10 20; 30 40], R=4, K=8.
  - State is READ after start, CALCULATE after 4 edges, WRITE after 8 more.
  - `out_c` = 700, 1000, 1500, 2200 on successive WRITE edges, then IDLE.
- Non-square: A 2×3 [1..6], B 3×1 [1,1,1] → C = 6, 15; R=6, K=6.
- Hold/abort: keep `start`=1 in ERROR → stays ERROR; assert `rstn` during CALCULATE → IDLE and `out_c`=0 immediately.
- Wrap: A = B = 1×1 [65536] → C = 0.
